iencoder: RTL and testbench
===========================

IENCODER -- requirements
Module: iencoder

Interface
REQ-001 The block SHALL have parameter BUF_DEPTH, default 2, giving the output buffer depth in entries; legal values are powers of two, 2 or more.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the field set on the inputs is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a field set.
REQ-006 The block SHALL have port inst_type, input, `INST_TYPE_WIDTH bits: the instruction class.
REQ-007 The block SHALL have port funct, input, `FUNCT_WIDTH bits: the operation selector.
REQ-008 The block SHALL have ports rd, rs1 and rs2, input, `REG_WIDTH bits each: the register indices.
REQ-009 The block SHALL have port imm, input, `IMM_WIDTH bits: the immediate in decoded (sign-extended, unshifted) form.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_inst holds an encoded word.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes out_inst.
REQ-012 The block SHALL have port out_inst, output, `INST_WIDTH bits: the encoded RV32I instruction word.
REQ-013 The block SHALL have port err, output, 1 bit: a one-cycle pulse when an accepted field set is not encodable.
REQ-014 The block SHALL have port err_count, output, 8 bits: a saturating count of unencodable field sets.

Function
REQ-015 An input transfer SHALL occur on a rising edge where in_valid && in_ready; an output transfer SHALL occur on a rising edge where out_valid && out_ready.
REQ-016 in_ready SHALL equal (count < BUF_DEPTH), with no combinational path from out_ready.
REQ-017 out_valid SHALL equal (count != 0), and out_inst SHALL be the oldest buffered entry, held stable until that entry transfers.
REQ-018 Latency: a word accepted into an empty buffer at edge N SHALL be presented with out_valid high from edge N onward; the buffer SHALL be FIFO-ordered.
REQ-019 A simultaneous push and pop SHALL leave count unchanged; the read and write pointers SHALL wrap modulo BUF_DEPTH.
REQ-020 Each instruction class SHALL be encoded as follows:
- IMM: emits LUI, {imm[31:12], rd, `OPCODE_LUI}.
- AUIPC: the same layout with `OPCODE_AUIPC.
- JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- JALR and LOAD: {imm[11:0], rs1, funct3, rd, opcode}, with funct3 = 0 for JALR.
- STORE: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
- BRANCH: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
- INT_REG: {funct7, rs2, rs1, funct3, rd, opcode}.
- INT_IMM: {imm[11:0], rs1, funct3, rd, opcode}.
- FENCE: 32'h0000000F.
REQ-021 Immediate bits not listed for a class SHALL be ignored.
REQ-022 funct SHALL map to funct3/funct7 as follows:
- INT_REG: ADD 0/0, SUB 0/32, SLL 1/0, SLT 2/0, SLTU 3/0, XOR 4/0, SRL 5/0, SRA 5/32, OR 6/0, AND 7/0.
- INT_IMM: ADD 0, SLLI 1, SRLI 5, AND 7, SRAI 5; for SLLI, SRLI and SRAI, imm[11:0] is replaced by {funct7, imm[4:0]}, with funct7 = 32 for SRAI and 0 otherwise.
- BRANCH: EQ 0, NEQ 1, LT 4, GTE 5, LTU 6, GTEU 7.
- STORE: MEM_BYTE 0, MEM_HWORD 1, MEM_WORD 2.
- LOAD: the STORE mapping plus MEM_BYTEU 4, MEM_HWORDU 5.
REQ-023 Any inst_type/funct pair not listed in REQ-022, and any unknown inst_type, SHALL be unencodable; such a transfer SHALL be accepted but not buffered.
REQ-024 err SHALL be high for exactly the cycle after an unencodable transfer.
REQ-025 err_count SHALL increment by one per unencodable transfer and SHALL saturate at 255.
REQ-026 Round-trip: for every encodable field set produced by the team's instruction decoder from a canonical RV32I word W, the block SHALL emit W.

Reset
REQ-027 While rst is low, the block SHALL hold count = 0, both pointers = 0, out_valid = 0, in_ready = 1, err = 0, err_count = 0 and out_inst = 0.
REQ-028 Assertion of rst mid-operation SHALL discard all buffered entries immediately, with no output transfer completing on that edge.

Verification
REQ-029 The bench SHALL drive INT_IMM/ADD with rd = 1, rs1 = 0, imm = 5 into an empty buffer with out_ready high, and SHALL check out_inst = 0x00500093 on the next cycle.
REQ-030 The bench SHALL drive INT_REG/SUB with rd = 3, rs1 = 1, rs2 = 2 -> 0x402081B3, and INT_IMM/SRAI with rd = 5, rs1 = 6, imm = 3 -> 0x40335293.
REQ-031 The bench SHALL drive BRANCH/EQ with rs1 = 1, rs2 = 2, imm = 0xFFFFFFFC and SHALL check 0xFE208EE3.
REQ-032 The bench SHALL hold out_ready low and offer three valid sets (BUF_DEPTH = 2); it SHALL check in_ready low after two accepts and the third held, then raise out_ready and check all three words emerge in order.
REQ-033 The bench SHALL drive INT_REG with funct = FUNCT_EQ and SHALL check in_ready high, err pulsing for one cycle, err_count = 1 and out_valid staying low; it SHALL then apply 300 such sets and check err_count = 255.
REQ-034 The bench SHALL fill the buffer, assert rst for one cycle mid-stream, and SHALL check out_valid = 0, in_ready = 1 and err_count = 0 immediately, with no stale word emitted afterwards.

Source files
------------

// File: rtl/iencoder.sv
// RV32I instruction encoder: turns a decoded field set back into a 32-bit word
// and presents it through a small FIFO, flagging field sets with no RV32I encoding.
`ifndef IENCODER_DEFS
`define IENCODER_DEFS
`define INST_TYPE_WIDTH 4
`define FUNCT_WIDTH     5
`define REG_WIDTH       5
`define IMM_WIDTH       32
`define INST_WIDTH      32

`define INST_TYPE_IMM     4'd0
`define INST_TYPE_AUIPC   4'd1
`define INST_TYPE_JAL     4'd2
`define INST_TYPE_JALR    4'd3
`define INST_TYPE_BRANCH  4'd4
`define INST_TYPE_LOAD    4'd5
`define INST_TYPE_STORE   4'd6
`define INST_TYPE_INT_REG 4'd7
`define INST_TYPE_INT_IMM 4'd8
`define INST_TYPE_FENCE   4'd9

`define FUNCT_ADD        5'd0
`define FUNCT_SUB        5'd1
`define FUNCT_SLL        5'd2
`define FUNCT_SLT        5'd3
`define FUNCT_SLTU       5'd4
`define FUNCT_XOR        5'd5
`define FUNCT_SRL        5'd6
`define FUNCT_SRA        5'd7
`define FUNCT_OR         5'd8
`define FUNCT_AND        5'd9
`define FUNCT_SLLI       5'd10
`define FUNCT_SRLI       5'd11
`define FUNCT_SRAI       5'd12
`define FUNCT_EQ         5'd13
`define FUNCT_NEQ        5'd14
`define FUNCT_LT         5'd15
`define FUNCT_GTE        5'd16
`define FUNCT_LTU        5'd17
`define FUNCT_GTEU       5'd18
`define FUNCT_MEM_BYTE   5'd19
`define FUNCT_MEM_HWORD  5'd20
`define FUNCT_MEM_WORD   5'd21
`define FUNCT_MEM_BYTEU  5'd22
`define FUNCT_MEM_HWORDU 5'd23

`define OPCODE_LUI    7'b0110111
`define OPCODE_AUIPC  7'b0010111
`define OPCODE_JAL    7'b1101111
`define OPCODE_JALR   7'b1100111
`define OPCODE_BRANCH 7'b1100011
`define OPCODE_LOAD   7'b0000011
`define OPCODE_STORE  7'b0100011
`define OPCODE_OP     7'b0110011
`define OPCODE_OP_IMM 7'b0010011
`endif

module iencoder #(
  parameter int BUF_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [`INST_TYPE_WIDTH-1:0]   inst_type,
  input  logic [`FUNCT_WIDTH-1:0]       funct,
  input  logic [`REG_WIDTH-1:0]         rd,
  input  logic [`REG_WIDTH-1:0]         rs1,
  input  logic [`REG_WIDTH-1:0]         rs2,
  input  logic [`IMM_WIDTH-1:0]         imm,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [`INST_WIDTH-1:0]        out_inst,
  output logic                          err,
  output logic [7:0]                    err_count
);

  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(BUF_DEPTH);

  logic [AW:0]             count_q, count_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [`INST_WIDTH-1:0]  mem_q [BUF_DEPTH];
  logic                    err_q, err_d;
  logic [7:0]              err_count_q, err_count_d;

  logic                    enc_ok;
  logic [`INST_WIDTH-1:0]  enc_word;
  logic [2:0]              f3;
  logic [6:0]              f7;
  logic [11:0]             imm12;
  logic                    accept, push, pop;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path leaves a variable unassigned and infers a latch.
  always_comb begin
    enc_ok   = 1'b1;
    enc_word = '0;
    f3       = 3'd0;
    f7       = 7'd0;
    imm12    = imm[11:0];
    case (inst_type)
      `INST_TYPE_IMM:   enc_word = {imm[31:12], rd, `OPCODE_LUI};
      `INST_TYPE_AUIPC: enc_word = {imm[31:12], rd, `OPCODE_AUIPC};
      `INST_TYPE_JAL:
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, `OPCODE_JAL};
      `INST_TYPE_JALR:  enc_word = {imm[11:0], rs1, 3'd0, rd, `OPCODE_JALR};
      `INST_TYPE_LOAD: begin
        case (funct)
          `FUNCT_MEM_BYTE:   f3 = 3'd0;
          `FUNCT_MEM_HWORD:  f3 = 3'd1;
          `FUNCT_MEM_WORD:   f3 = 3'd2;
          `FUNCT_MEM_BYTEU:  f3 = 3'd4;
          `FUNCT_MEM_HWORDU: f3 = 3'd5;
          default:           enc_ok = 1'b0;
        endcase
        enc_word = {imm[11:0], rs1, f3, rd, `OPCODE_LOAD};
      end
      `INST_TYPE_STORE: begin
        case (funct)
          `FUNCT_MEM_BYTE:  f3 = 3'd0;
          `FUNCT_MEM_HWORD: f3 = 3'd1;
          `FUNCT_MEM_WORD:  f3 = 3'd2;
          default:          enc_ok = 1'b0;
        endcase
        enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], `OPCODE_STORE};
      end
      `INST_TYPE_BRANCH: begin
        case (funct)
          `FUNCT_EQ:   f3 = 3'd0;
          `FUNCT_NEQ:  f3 = 3'd1;
          `FUNCT_LT:   f3 = 3'd4;
          `FUNCT_GTE:  f3 = 3'd5;
          `FUNCT_LTU:  f3 = 3'd6;
          `FUNCT_GTEU: f3 = 3'd7;
          default:     enc_ok = 1'b0;
        endcase
        enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], `OPCODE_BRANCH};
      end
      `INST_TYPE_INT_REG: begin
        case (funct)
          `FUNCT_ADD:  f3 = 3'd0;
          `FUNCT_SUB:  begin f3 = 3'd0; f7 = 7'd32; end
          `FUNCT_SLL:  f3 = 3'd1;
          `FUNCT_SLT:  f3 = 3'd2;
          `FUNCT_SLTU: f3 = 3'd3;
          `FUNCT_XOR:  f3 = 3'd4;
          `FUNCT_SRL:  f3 = 3'd5;
          `FUNCT_SRA:  begin f3 = 3'd5; f7 = 7'd32; end
          `FUNCT_OR:   f3 = 3'd6;
          `FUNCT_AND:  f3 = 3'd7;
          default:     enc_ok = 1'b0;
        endcase
        enc_word = {f7, rs2, rs1, f3, rd, `OPCODE_OP};
      end
      `INST_TYPE_INT_IMM: begin
        // Shift-immediates carry funct7 in the upper immediate bits.
        case (funct)
          `FUNCT_ADD:  f3 = 3'd0;
          `FUNCT_SLLI: begin f3 = 3'd1; imm12 = {7'd0, imm[4:0]}; end
          `FUNCT_SRLI: begin f3 = 3'd5; imm12 = {7'd0, imm[4:0]}; end
          `FUNCT_SRAI: begin f3 = 3'd5; imm12 = {7'd32, imm[4:0]}; end
          `FUNCT_AND:  f3 = 3'd7;
          default:     enc_ok = 1'b0;
        endcase
        enc_word = {imm12, rs1, f3, rd, `OPCODE_OP_IMM};
      end
      `INST_TYPE_FENCE: enc_word = 32'h0000000F;
      default:          enc_ok = 1'b0;
    endcase
  end

  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign out_inst  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign err       = err_q;
  assign err_count = err_count_q;

  assign accept = in_valid && in_ready;
  assign push   = accept && enc_ok;
  assign pop    = out_valid && out_ready;

  always_comb begin
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    err_d       = accept && !enc_ok;
    err_count_d = err_count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (err_d && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      err_q       <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  // NOTE: the storage array has no reset; out_inst is masked to zero while
  // the buffer is empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= enc_word;
  end

endmodule

// File: tb/tb_iencoder.sv
// Scoreboard bench for iencoder: directed field sets with hand-computed words,
// back-pressure, error counting/saturation and mid-stream reset.
`ifndef IENCODER_DEFS
`define IENCODER_DEFS
`define INST_TYPE_WIDTH 4
`define FUNCT_WIDTH     5
`define REG_WIDTH       5
`define IMM_WIDTH       32
`define INST_WIDTH      32
`define INST_TYPE_IMM     4'd0
`define INST_TYPE_AUIPC   4'd1
`define INST_TYPE_JAL     4'd2
`define INST_TYPE_JALR    4'd3
`define INST_TYPE_BRANCH  4'd4
`define INST_TYPE_LOAD    4'd5
`define INST_TYPE_STORE   4'd6
`define INST_TYPE_INT_REG 4'd7
`define INST_TYPE_INT_IMM 4'd8
`define INST_TYPE_FENCE   4'd9
`define FUNCT_ADD        5'd0
`define FUNCT_SUB        5'd1
`define FUNCT_SLL        5'd2
`define FUNCT_SLT        5'd3
`define FUNCT_SLTU       5'd4
`define FUNCT_XOR        5'd5
`define FUNCT_SRL        5'd6
`define FUNCT_SRA        5'd7
`define FUNCT_OR         5'd8
`define FUNCT_AND        5'd9
`define FUNCT_SLLI       5'd10
`define FUNCT_SRLI       5'd11
`define FUNCT_SRAI       5'd12
`define FUNCT_EQ         5'd13
`define FUNCT_NEQ        5'd14
`define FUNCT_LT         5'd15
`define FUNCT_GTE        5'd16
`define FUNCT_LTU        5'd17
`define FUNCT_GTEU       5'd18
`define FUNCT_MEM_BYTE   5'd19
`define FUNCT_MEM_HWORD  5'd20
`define FUNCT_MEM_WORD   5'd21
`define FUNCT_MEM_BYTEU  5'd22
`define FUNCT_MEM_HWORDU 5'd23
`define OPCODE_LUI    7'b0110111
`define OPCODE_AUIPC  7'b0010111
`define OPCODE_JAL    7'b1101111
`define OPCODE_JALR   7'b1100111
`define OPCODE_BRANCH 7'b1100011
`define OPCODE_LOAD   7'b0000011
`define OPCODE_STORE  7'b0100011
`define OPCODE_OP     7'b0110011
`define OPCODE_OP_IMM 7'b0010011
`endif

module tb_iencoder;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, err;
  logic [3:0]  inst_type;
  logic [4:0]  funct, rd, rs1, rs2;
  logic [31:0] imm, out_inst;
  logic [7:0]  err_count;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  logic [31:0] sb [$];

  iencoder #(.BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst_type(inst_type), .funct(funct), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every output transfer is compared against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL stale_word: got 0x%08h expected no output", out_inst);
        end else begin
          logic [31:0] exp;
          exp = sb.pop_front();
          if (out_inst !== exp) begin
            n_fail++;
            $display("FAIL out_inst: got 0x%08h expected 0x%08h", out_inst, exp);
          end
        end
      end
    end
  end

  // Offer one field set; returns #1 after the accepting edge.
  task automatic send(input logic [3:0] t, input logic [4:0] f, input logic [4:0] rd_i,
                      input logic [4:0] rs1_i, input logic [4:0] rs2_i,
                      input logic [31:0] imm_i, input logic [31:0] exp, input bit ok);
    bit done = 0;
    inst_type = t; funct = f; rd = rd_i; rs1 = rs1_i; rs2 = rs2_i; imm = imm_i;
    in_valid  = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1;
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 expected 1");
      @(posedge clk); #1 in_valid = 1'b0;
      return;
    end
    if (ok) sb.push_back(exp);
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) done = 1;
    end
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain: %0d words outstanding expected 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    inst_type = '0; funct = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_err",       32'(err),       32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_out_inst",  out_inst,       32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single word into an empty buffer, consumer ready.
    out_ready = 1'b1;
    send(`INST_TYPE_INT_IMM, `FUNCT_ADD, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1);
    check("latency_out_valid", 32'(out_valid), 32'd1);
    drain();

    send(`INST_TYPE_INT_REG, `FUNCT_SUB,  5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3, 1);
    send(`INST_TYPE_INT_IMM, `FUNCT_SRAI, 5'd5, 5'd6, 5'd0, 32'd3, 32'h40335293, 1);
    send(`INST_TYPE_BRANCH,  `FUNCT_EQ,   5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE208EE3, 1);
    send(`INST_TYPE_IMM,     `FUNCT_ADD,  5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1);
    send(`INST_TYPE_AUIPC,   `FUNCT_ADD,  5'd1, 5'd0, 5'd0, 32'hFFFFF000, 32'hFFFFF097, 1);
    send(`INST_TYPE_JAL,     `FUNCT_ADD,  5'd1, 5'd0, 5'd0, 32'd8,        32'h008000EF, 1);
    send(`INST_TYPE_JALR,    `FUNCT_ADD,  5'd0, 5'd1, 5'd0, 32'd0,        32'h00008067, 1);
    send(`INST_TYPE_LOAD,    `FUNCT_MEM_WORD,  5'd10, 5'd2, 5'd0, 32'd4,  32'h00412503, 1);
    send(`INST_TYPE_LOAD,    `FUNCT_MEM_BYTEU, 5'd1,  5'd2, 5'd0, 32'hFFFFFFFF, 32'hFFF14083, 1);
    send(`INST_TYPE_STORE,   `FUNCT_MEM_WORD,  5'd0,  5'd2, 5'd10, 32'd8, 32'h00A12423, 1);
    send(`INST_TYPE_INT_REG, `FUNCT_AND,  5'd1, 5'd2, 5'd3, 32'd0, 32'h003170B3, 1);
    send(`INST_TYPE_FENCE,   `FUNCT_ADD,  5'd0, 5'd0, 5'd0, 32'd0, 32'h0000000F, 1);
    drain();

    // Back-pressure: two accepted, third held until the consumer is ready.
    out_ready = 1'b0;
    send(`INST_TYPE_INT_IMM, `FUNCT_ADD, 5'd1, 5'd0, 5'd0, 32'd1, 32'h00100093, 1);
    send(`INST_TYPE_INT_IMM, `FUNCT_ADD, 5'd2, 5'd0, 5'd0, 32'd2, 32'h00200113, 1);
    fork
      send(`INST_TYPE_INT_IMM, `FUNCT_ADD, 5'd3, 5'd0, 5'd0, 32'd3, 32'h00300193, 1);
      begin
        repeat (3) @(negedge clk);
        check("full_in_ready",  32'(in_ready),  32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_sb_held",   32'(sb.size()), 32'd2);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();

    // Unencodable field set: accepted, not buffered, one-cycle err pulse.
    send(`INST_TYPE_INT_REG, `FUNCT_EQ, 5'd1, 5'd1, 5'd1, 32'd0, 32'd0, 0);
    check("err_pulse",      32'(err),       32'd1);
    check("err_count_1",    32'(err_count), 32'd1);
    check("err_out_valid",  32'(out_valid), 32'd0);
    check("err_in_ready",   32'(in_ready),  32'd1);
    @(posedge clk); #1;
    check("err_pulse_end",  32'(err),       32'd0);
    check("err_out_valid2", 32'(out_valid), 32'd0);

    for (int i = 0; i < 300; i++)
      send(`INST_TYPE_INT_REG, `FUNCT_EQ, 5'd1, 5'd1, 5'd1, 32'd0, 32'd0, 0);
    check("err_count_sat", 32'(err_count), 32'd255);
    send(`INST_TYPE_STORE, `FUNCT_MEM_BYTEU, 5'd0, 5'd1, 5'd2, 32'd0, 32'd0, 0);
    send(4'hF, `FUNCT_ADD, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 0);
    check("err_count_hold", 32'(err_count), 32'd255);
    drain();

    // Mid-stream reset with a full buffer.
    out_ready = 1'b0;
    send(`INST_TYPE_INT_IMM, `FUNCT_ADD, 5'd4, 5'd0, 5'd0, 32'd4, 32'h00400213, 1);
    send(`INST_TYPE_INT_IMM, `FUNCT_ADD, 5'd5, 5'd0, 5'd0, 32'd5, 32'h00500293, 1);
    check("pre_rst_in_ready", 32'(in_ready), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    check("mid_rst_err_count", 32'(err_count), 32'd0);
    check("mid_rst_out_inst",  out_inst,       32'd0);
    sb.delete();
    out_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    send(`INST_TYPE_INT_REG, `FUNCT_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 32'h003100B3, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
